// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared geometry constants for the weight tile packer
// Purpose: tile/beat geometry used by weight_tile_packer and tile_slot.
// Ports: none (package).
package weight_pkg;

  localparam int WEIGHT_W      = 4;
  localparam int DATA_W        = 64;
  localparam int TILE_W        = 4096;
  localparam int BEATS         = TILE_W / DATA_W;
  localparam int CNT_W         = $clog2(BEATS);
  localparam int IDX_PER_BEAT  = DATA_W / WEIGHT_W;
  localparam int IDX_PER_LUT   = 64;
  localparam int BEATS_PER_LUT = IDX_PER_LUT / IDX_PER_BEAT;

  // True on the beat position that fills the final DATA_W bits of a tile.
  function automatic logic is_final_beat(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(BEATS - 1);
  endfunction

endpackage

// File: rtl/tile_slot.sv
// rtl/tile_slot.sv - one TILE_W-bit tile register with beat-indexed write
// Purpose: holds one tile of the ping-pong buffer.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en_i     write wr_data_i into beat position wr_beat_i
//   wr_beat_i   beat index within the tile
//   wr_data_i   DATA_W-bit beat
//   clr_i       synchronous clear of the whole tile (has priority over write)
//   data_o      registered tile contents
module tile_slot
  import weight_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [CNT_W-1:0]  wr_beat_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_i,
  output logic [TILE_W-1:0] data_o
);

  logic [TILE_W-1:0] data_q;

  // Clearing on release keeps beats that an early-closed tile never wrote at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      data_q[wr_beat_i*DATA_W +: DATA_W] <= wr_data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/weight_tile_packer.sv
// rtl/weight_tile_packer.sv - packs DATA_W-bit weight-index beats into TILE_W-bit tiles
// Purpose: ping-pong double buffer feeding the LUT-bank lookup stage.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   s_data       input beat; beat k lands at tile bits [k*DATA_W +: DATA_W]
//   s_valid      beat valid
//   s_last       last beat of tile (qualified by s_valid)
//   s_ready      beat accepted when s_valid && s_ready
//   tile_data    tile held in the read slot
//   tile_valid   read slot holds a complete tile
//   tile_ready   consumer takes the tile on tile_valid && tile_ready
//   err_framing  one-cycle pulse after a mis-framed tile close
//   tiles_done   wrapping count of tiles handed off
module weight_tile_packer
  import weight_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [TILE_W-1:0] tile_data,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              err_framing,
  output logic [15:0]       tiles_done
);

  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic [15:0]      done_q, done_d;

  logic             accept;
  logic             final_beat;
  logic             close;
  logic             drain;
  logic [TILE_W-1:0] slot_data [2];

  // Ready depends only on registered flags, so tile_ready never reaches s_ready.
  assign s_ready    = !full_q[wr_sel_q];
  assign accept     = s_valid && s_ready;
  assign final_beat = is_final_beat(beat_cnt_q);
  assign close      = accept && (s_last || final_beat);
  assign drain      = full_q[rd_sel_q] && tile_ready;

  // Write and clear never target the same slot: only an empty slot accepts
  // beats and only a full slot is drained.
  for (genvar i = 0; i < 2; i++) begin : g_slot
    tile_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (accept && (wr_sel_q == 1'(i))),
      .wr_beat_i (beat_cnt_q),
      .wr_data_i (s_data),
      .clr_i     (drain && (rd_sel_q == 1'(i))),
      .data_o    (slot_data[i])
    );
  end

  always_comb begin
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = done_q;
    // Error when s_last and the final beat position disagree.
    err_d      = accept && (s_last != final_beat);

    if (accept) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
    if (close) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
      beat_cnt_d       = '0;
    end
    if (drain) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
      done_d           = done_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= '0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign tile_valid  = full_q[rd_sel_q];
  assign tile_data   = slot_data[rd_sel_q];
  assign err_framing = err_q;
  assign tiles_done  = done_q;

endmodule

// File: tb/tb_weight_tile_packer.sv
// tb/tb_weight_tile_packer.sv - self-checking bench for weight_tile_packer
module tb_weight_tile_packer;
  import weight_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [TILE_W-1:0] tile_data;
  logic              tile_valid;
  logic              tile_ready;
  logic              err_framing;
  logic [15:0]       tiles_done;

  weight_tile_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tile_data   (tile_data),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .err_framing (err_framing),
    .tiles_done  (tiles_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;

  // Reference model: completed tiles waiting for the consumer, plus the tile being built.
  logic [TILE_W-1:0] held [$];
  logic [TILE_W-1:0] cur;
  int                cnt;
  logic              err_exp;
  logic [15:0]       done_exp;

  logic        smp_rdy, smp_tv, smp_err;
  logic [15:0] smp_done;

  typedef struct {
    logic        v, l, r;
    logic        rdy, tv, err;
    logic [15:0] done;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tile(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    int first;
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      first = 0;
      for (int k = 0; k < BEATS; k++) begin
        if (act[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) begin
          first = k;
          break;
        end
      end
      $display("FAIL %s: beat %0d got %0h expected %0h (t=%0t)", name, first,
               act[first*DATA_W +: DATA_W], exp[first*DATA_W +: DATA_W], $time);
    end
  endtask

  task automatic model_reset();
    held.delete();
    cur      = '0;
    cnt      = 0;
    err_exp  = 1'b0;
    done_exp = '0;
  endtask

  task automatic compare_outputs();
    chk("s_ready", 64'(s_ready), 64'(held.size() < 2));
    chk("tile_valid", 64'(tile_valid), 64'(held.size() > 0));
    chk_tile("tile_data", tile_data, (held.size() > 0) ? held[0] : cur);
    chk("err_framing", 64'(err_framing), 64'(err_exp));
    chk("tiles_done", 64'(tiles_done), 64'(done_exp));
  endtask

  // One clock: drive at posedge+1, sample/compare at negedge, advance the model.
  task automatic step(input logic v, input logic l, input logic [DATA_W-1:0] d, input logic r);
    logic acc, drn, e;
    logic [TILE_W-1:0] tmp;
    s_valid = v; s_last = l; s_data = d; tile_ready = r;
    @(negedge clk);
    compare_outputs();
    smp_rdy = s_ready; smp_tv = tile_valid; smp_err = err_framing; smp_done = tiles_done;
    if (err_framing) err_seen++;
    acc = v && (held.size() < 2);
    drn = r && (held.size() > 0);
    e   = 1'b0;
    if (drn) begin
      tmp = held.pop_front();
      done_exp++;
    end
    if (acc) begin
      cur[cnt*DATA_W +: DATA_W] = d;
      e = (l != (cnt == BEATS - 1));
      if (l || cnt == BEATS - 1) begin
        held.push_back(cur);
        cur = '0;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    err_exp = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; tile_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_outputs();
    rst_n = 1'b1;
  endtask

  task automatic drain_all();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int e0;
    logic [15:0] d0;

    tbl[0] = '{v:1, l:1, r:0, rdy:1, tv:0, err:0, done:16'd0};
    tbl[1] = '{v:1, l:1, r:0, rdy:1, tv:1, err:1, done:16'd0};
    tbl[2] = '{v:1, l:0, r:0, rdy:0, tv:1, err:1, done:16'd0};
    tbl[3] = '{v:0, l:0, r:1, rdy:0, tv:1, err:0, done:16'd0};
    tbl[4] = '{v:0, l:0, r:1, rdy:1, tv:1, err:0, done:16'd1};
    tbl[5] = '{v:0, l:0, r:0, rdy:1, tv:0, err:0, done:16'd2};

    do_reset();

    // Table: two one-beat tiles fill both slots, then two drains.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].l, 64'(i + 1), tbl[i].r);
      chk("tbl_s_ready", 64'(smp_rdy), 64'(tbl[i].rdy));
      chk("tbl_tile_valid", 64'(smp_tv), 64'(tbl[i].tv));
      chk("tbl_err", 64'(smp_err), 64'(tbl[i].err));
      chk("tbl_done", 64'(smp_done), 64'(tbl[i].done));
    end

    // Full tile with s_data = beat number.
    do_reset();
    e0 = err_seen;
    for (int k = 0; k < BEATS; k++) step(1'b1, k == BEATS - 1, 64'(k), 1'b0);
    chk("t1_tile_valid", 64'(tile_valid), 64'd1);
    for (int k = 0; k < BEATS; k += 9) chk("t1_beat", tile_data[k*DATA_W +: DATA_W], 64'(k));
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t1_no_err", 64'(err_seen - e0), 64'd0);
    drain_all();

    // Both slots fill with tile_ready low; drain frees the write slot next cycle.
    for (int i = 0; i < 2 * BEATS; i++)
      step(1'b1, (i % BEATS) == BEATS - 1, {$urandom, $urandom}, 1'b0);
    step(1'b1, 1'b0, 64'hdead, 1'b0);
    chk("t2_s_ready_full", 64'(s_ready), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("t2_s_ready_after_drain", 64'(s_ready), 64'd1);
    drain_all();

    // Early close on beat index 9.
    e0 = err_seen;
    for (int k = 0; k < 10; k++) step(1'b1, k == 9, {32'hA5A5_0000, 32'(k)}, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t3_upper_zero", 64'(tile_data[TILE_W-1:640] == '0), 64'd1);
    chk("t3_beat9", tile_data[9*DATA_W +: DATA_W], {32'hA5A5_0000, 32'd9});
    chk("t3_err_once", 64'(err_seen - e0), 64'd1);
    drain_all();

    // Full tile without s_last.
    e0 = err_seen;
    for (int k = 0; k < BEATS; k++) step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t4_tile_valid", 64'(tile_valid), 64'd1);
    chk("t4_err_once", 64'(err_seen - e0), 64'd1);
    drain_all();

    // Continuous stream, consumer always ready.
    d0 = tiles_done;
    for (int i = 0; i < 4 * BEATS; i++) begin
      step(1'b1, (i % BEATS) == BEATS - 1, {$urandom, $urandom}, 1'b1);
      chk("t5_s_ready", 64'(smp_rdy), 64'd1);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("t5_tiles_done", 64'(tiles_done - d0), 64'd4);

    // Reset mid-tile with one tile held.
    for (int i = 0; i < BEATS + 30; i++)
      step(1'b1, i == BEATS - 1, {$urandom, $urandom}, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t6_s_ready", 64'(s_ready), 64'd1);
    chk("t6_tile_valid", 64'(tile_valid), 64'd0);
    chk("t6_tile_zero", 64'(tile_data == '0), 64'd1);
    chk("t6_err", 64'(err_framing), 64'd0);
    chk("t6_done", 64'(tiles_done), 64'd0);
    model_reset();
    s_valid = 1'b0; tile_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < BEATS; k++) step(1'b1, k == BEATS - 1, 64'(k + 100), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < BEATS; k += 13) chk("t6_clean_beat", tile_data[k*DATA_W +: DATA_W], 64'(k + 100));
    drain_all();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, ($urandom % 40) == 0, {$urandom, $urandom}, ($urandom % 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
